// File: rtl/sum_bcd_pkg.sv
// Shared definitions for the sum-to-BCD converter slice.
// Holds the FSM state encoding, the BCD digit width and the double-dabble
// add-3 threshold. Imported by the interface, the digit adjuster and the top.
package sum_bcd_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  typedef enum logic [1:0] {
    StIdle  = ST_IDLE,
    StShift = ST_SHIFT,
    StDone  = ST_DONE
  } state_e;

  localparam int unsigned BCD_DIGIT_W = 4;

  // A digit at or above this value would reach >= 10 after the next shift.
  localparam logic [BCD_DIGIT_W-1:0] ADD3_THRESHOLD = 4'd5;
  localparam logic [BCD_DIGIT_W-1:0] ADD3_OFFSET    = 4'd3;

endpackage

// File: rtl/sum_bcd_converter_if.sv
// Handshake bundle between the adder, the BCD converter and the display path.
// Optional macro: LEADING_ZERO_BLANK_EN adds digit_en.
// Signals:
//   in_valid/in_ready   operand handshake (upstream -> converter)
//   sum/cout            adder result, {cout, sum} is the value converted
//   out_valid/out_ready result handshake (converter -> consumer)
//   bcd                 packed BCD, digit 0 in bits [3:0]
//   busy                conversion in progress
//   digit_en            (optional) per-digit leading-zero blanking mask
// Modports: master = upstream/consumer side, slave = converter.
interface sum_bcd_converter_if #(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned DIGITS = 6
);
  import sum_bcd_pkg::*;

  logic                          in_valid;
  logic                          in_ready;
  logic [WIDTH-1:0]              sum;
  logic                          cout;
  logic                          out_valid;
  logic                          out_ready;
  logic [BCD_DIGIT_W*DIGITS-1:0] bcd;
  logic                          busy;
`ifdef LEADING_ZERO_BLANK_EN
  logic [DIGITS-1:0]             digit_en;
`endif

  modport master (
    output in_valid, sum, cout, out_ready,
`ifdef LEADING_ZERO_BLANK_EN
    input  digit_en,
`endif
    input  in_ready, out_valid, bcd, busy
  );

  modport slave (
    input  in_valid, sum, cout, out_ready,
`ifdef LEADING_ZERO_BLANK_EN
    output digit_en,
`endif
    output in_ready, out_valid, bcd, busy
  );

endinterface

// File: rtl/bcd_add3_digit.sv
// Double-dabble digit correction: adds 3 to a BCD digit that is >= 5 so the
// following left shift carries correctly into the next decimal digit.
// Ports:
//   digit     4-bit BCD digit before the shift
//   adjusted  corrected digit (never overflows since digit <= 9)
module bcd_add3_digit
  import sum_bcd_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] digit,
  output logic [BCD_DIGIT_W-1:0] adjusted
);

  always_comb begin
    adjusted = digit;
    if (digit >= ADD3_THRESHOLD) begin
      adjusted = digit + ADD3_OFFSET;
    end
  end

endmodule

// File: rtl/sum_bcd_converter.sv
// Sequential binary-to-BCD converter for the adder result {cout, sum}.
// One double-dabble step per clock: accept in IDLE, WIDTH+1 shifts in SHIFT,
// then hold the result in DONE until the consumer takes it.
// Optional macro: LEADING_ZERO_BLANK_EN adds the registered digit_en mask.
// Ports:
//   clk   rising-edge clock
//   rst   synchronous, active-high reset
//   bus   sum_bcd_converter_if.slave (in/out handshakes, sum, cout, bcd, busy)
module sum_bcd_converter
  import sum_bcd_pkg::*;
#(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned DIGITS = 6
) (
  input  logic                 clk,
  input  logic                 rst,
  sum_bcd_converter_if.slave   bus
);

  localparam int unsigned BIN_W = WIDTH + 1;
  localparam int unsigned ACC_W = BCD_DIGIT_W * DIGITS;
  localparam int unsigned CNT_W = $clog2(WIDTH + 2);

  state_e             state_q, state_d;
  logic [BIN_W-1:0]   bin_q, bin_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [ACC_W-1:0]   acc_adj;
  logic [ACC_W-1:0]   acc_shift;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [ACC_W-1:0]   bcd_q, bcd_d;
  logic               load_result;

  // Per-digit add-3 correction ahead of the shift.
  for (genvar i = 0; i < DIGITS; i++) begin : g_add3
    bcd_add3_digit u_add3 (
      .digit    (acc_q[i*BCD_DIGIT_W +: BCD_DIGIT_W]),
      .adjusted (acc_adj[i*BCD_DIGIT_W +: BCD_DIGIT_W])
    );
  end

  // Corrected accumulator shifted left, pulling in the binary MSB.
  assign acc_shift = {acc_adj[ACC_W-2:0], bin_q[BIN_W-1]};

  always_comb begin
    state_d     = state_q;
    bin_d       = bin_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    bcd_d       = bcd_q;
    load_result = 1'b0;

    case (state_q)
      StIdle: begin
        if (bus.in_valid) begin
          bin_d   = {bus.cout, bus.sum};
          acc_d   = '0;
          cnt_d   = CNT_W'(BIN_W);
          state_d = StShift;
        end
      end
      StShift: begin
        acc_d = acc_shift;
        bin_d = {bin_q[BIN_W-2:0], 1'b0};
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          bcd_d       = acc_shift;
          load_result = 1'b1;
          state_d     = StDone;
        end
      end
      StDone: begin
        if (bus.out_ready) begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      bin_q   <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      bcd_q   <= '0;
    end else begin
      state_q <= state_d;
      bin_q   <= bin_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      bcd_q   <= bcd_d;
    end
  end

  assign bus.in_ready  = (state_q == StIdle);
  assign bus.busy      = (state_q == StShift);
  assign bus.out_valid = (state_q == StDone);
  assign bus.bcd       = bcd_q;

`ifdef LEADING_ZERO_BLANK_EN
  logic [DIGITS-1:0] digit_en_q, digit_en_d;

  // Scan from the most significant digit; once a nonzero digit is seen every
  // lower digit is shown. The units digit is always shown.
  always_comb begin
    logic seen;
    seen       = 1'b0;
    digit_en_d = '0;
    for (int i = int'(DIGITS) - 1; i >= 0; i--) begin
      seen          = seen | (acc_shift[i*BCD_DIGIT_W +: BCD_DIGIT_W] != '0);
      digit_en_d[i] = seen;
    end
    digit_en_d[0] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      digit_en_q <= DIGITS'(1);
    end else if (load_result) begin
      digit_en_q <= digit_en_d;
    end
  end

  assign bus.digit_en = digit_en_q;
`else
  logic unused_load_result;
  assign unused_load_result = load_result;
`endif

endmodule

// File: tb/tb_sum_bcd_converter.sv
// Directed bench for sum_bcd_converter: latency, conversion values, output
// hold under backpressure, and reset in the middle of a conversion.
module tb_sum_bcd_converter;

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;
  int   lat;

  always #5 clk = ~clk;

  sum_bcd_converter_if #(.WIDTH(16), .DIGITS(6)) dut_if ();

  sum_bcd_converter #(
    .WIDTH  (16),
    .DIGITS (6)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (dut_if)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one operand in IDLE, then count edges until out_valid (bounded).
  task automatic convert(input logic c, input logic [15:0] s, output int latency);
    dut_if.cout     = c;
    dut_if.sum      = s;
    dut_if.in_valid = 1'b1;
    tick();
    dut_if.in_valid = 1'b0;
    check("accept_in_ready_low", 32'(dut_if.in_ready), 32'd0);
    check("accept_busy_high", 32'(dut_if.busy), 32'd1);
    latency = 0;
    while (dut_if.out_valid !== 1'b1 && latency < 40) begin
      tick();
      latency++;
    end
  endtask

  task automatic take_result();
    dut_if.out_ready = 1'b1;
    tick();
    dut_if.out_ready = 1'b0;
    check("after_hs_out_valid", 32'(dut_if.out_valid), 32'd0);
    check("after_hs_in_ready", 32'(dut_if.in_ready), 32'd1);
  endtask

  initial begin
    rst              = 1'b1;
    dut_if.in_valid  = 1'b0;
    dut_if.sum       = '0;
    dut_if.cout      = 1'b0;
    dut_if.out_ready = 1'b0;
    tick();
    tick();
    check("rst_in_ready", 32'(dut_if.in_ready), 32'd1);
    check("rst_out_valid", 32'(dut_if.out_valid), 32'd0);
    check("rst_busy", 32'(dut_if.busy), 32'd0);
    check("rst_bcd", 32'(dut_if.bcd), 32'h0);
`ifdef LEADING_ZERO_BLANK_EN
    check("rst_digit_en", 32'(dut_if.digit_en), 32'b000001);
`endif
    rst = 1'b0;

    // 1 + 2
    convert(1'b0, 16'd3, lat);
    check("lat_3", 32'(lat), 32'd17);
    check("bcd_3", 32'(dut_if.bcd), 32'h000003);
    check("busy_done_3", 32'(dut_if.busy), 32'd0);
    take_result();

    // 7 + 10, then 20 + 30
    convert(1'b0, 16'd17, lat);
    check("lat_17", 32'(lat), 32'd17);
    check("bcd_17", 32'(dut_if.bcd), 32'h000017);
    take_result();
    convert(1'b0, 16'd50, lat);
    check("bcd_50", 32'(dut_if.bcd), 32'h000050);
`ifdef LEADING_ZERO_BLANK_EN
    check("digit_en_50", 32'(dut_if.digit_en), 32'b000011);
`endif
    take_result();

    // 0xFFFF + 1 and the maximum value
    convert(1'b1, 16'h0000, lat);
    check("bcd_65536", 32'(dut_if.bcd), 32'h065536);
    take_result();
    convert(1'b1, 16'hFFFF, lat);
    check("lat_131071", 32'(lat), 32'd17);
    check("bcd_131071", 32'(dut_if.bcd), 32'h131071);
`ifdef LEADING_ZERO_BLANK_EN
    check("digit_en_131071", 32'(dut_if.digit_en), 32'b111111);
`endif
    take_result();

    convert(1'b0, 16'd0, lat);
    check("bcd_0", 32'(dut_if.bcd), 32'h000000);
`ifdef LEADING_ZERO_BLANK_EN
    check("digit_en_0", 32'(dut_if.digit_en), 32'b000001);
`endif
    take_result();

    // Backpressure in DONE with upstream noise.
    convert(1'b0, 16'd1234, lat);
    check("bcd_1234", 32'(dut_if.bcd), 32'h001234);
    for (int k = 0; k < 5; k++) begin
      dut_if.sum      = 16'((k + 1) * 777);
      dut_if.in_valid = 1'b1;
      tick();
      check("hold_out_valid", 32'(dut_if.out_valid), 32'd1);
      check("hold_bcd", 32'(dut_if.bcd), 32'h001234);
      check("hold_in_ready", 32'(dut_if.in_ready), 32'd0);
    end
    dut_if.in_valid = 1'b0;
    take_result();
    check("bcd_kept_after_hs", 32'(dut_if.bcd), 32'h001234);
    check("busy_idle", 32'(dut_if.busy), 32'd0);

    // Reset at the 8th shift edge.
    dut_if.cout     = 1'b0;
    dut_if.sum      = 16'd4321;
    dut_if.in_valid = 1'b1;
    tick();
    dut_if.in_valid = 1'b0;
    repeat (7) tick();
    check("mid_shift_busy", 32'(dut_if.busy), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_in_ready", 32'(dut_if.in_ready), 32'd1);
    check("midrst_out_valid", 32'(dut_if.out_valid), 32'd0);
    check("midrst_bcd", 32'(dut_if.bcd), 32'h0);
    check("midrst_busy", 32'(dut_if.busy), 32'd0);
    repeat (12) tick();
    check("midrst_no_result", 32'(dut_if.out_valid), 32'd0);

    convert(1'b0, 16'd99, lat);
    check("lat_99", 32'(lat), 32'd17);
    check("bcd_99", 32'(dut_if.bcd), 32'h000099);
    take_result();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
